// File: rtl/contrast_pkg.sv
// contrast_pkg: state encoding and full-scale helper shared by the contrast stretcher
package contrast_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CALC, PROC, PRE, OUT, DONE} state_e;
    function automatic int full_scale(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/contrast_ram.sv
// contrast_ram: simple dual-port RAM with one write port and one registered, resettable read port
module contrast_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 76800,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wa_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] ra_i,
    output logic [DATA_WIDTH-1:0] rd_o
);
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk_i) if (we_i) mem_q[wa_i] <= wd_i;
    always_ff @(posedge clk_i) rd_q <= rst_i ? '0 : re_i ? mem_q[ra_i] : rd_q;
    assign rd_o = rd_q;
endmodule

// File: rtl/top_contrast_stretching.sv
// top_contrast_stretching: buffers a frame, tracks min/max, remaps it to full scale and streams it out
module top_contrast_stretching
    import contrast_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 76800,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i_top_contrast,
    input  logic                  rst_i_top_contrast,
    input  logic                  en_i_top_contrast,
    input  logic [DATA_WIDTH-1:0] data_i_top_contrast,
    output logic [DATA_WIDTH-1:0] data_o_top_contrast,
    output logic                  done_process,
    output logic                  done_o_top_contrast
);
    localparam int CW = $clog2(RAM_DEPTH + 1);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] LAST  = CW'(RAM_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH = CW'(RAM_DEPTH);
    localparam logic [PW-1:0] FULL  = PW'(full_scale(DATA_WIDTH));

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d, range_q, range_d;
    logic [DATA_WIDTH-1:0] in_rd, diff, pix_out;
    logic [PW-1:0] prod;
    logic [ADDR_WIDTH-1:0] out_ra;
    logic done_process_q, done_o_q, in_we, in_re, out_we, out_re;

    assign diff    = in_rd - min_q;
    assign prod    = PW'(diff) * FULL;
    assign pix_out = range_q == '0 ? '0 : DATA_WIDTH'(prod / PW'(range_q));
    // PROC issues reads for cnt 0..DEPTH-1 and writes the result one cycle later
    assign in_re  = state_q == PROC && cnt_q < DEPTH;
    assign out_we = state_q == PROC && cnt_q != '0 && en_i_top_contrast;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        range_d = range_q;
        in_we   = 1'b0;
        out_re  = 1'b0;
        out_ra  = '0;
        case (state_q)
            IDLE: state_d = en_i_top_contrast ? LOAD : IDLE;
            LOAD: begin
                in_we   = 1'b1;
                min_d   = data_i_top_contrast < min_q ? data_i_top_contrast : min_q;
                max_d   = data_i_top_contrast > max_q ? data_i_top_contrast : max_q;
                cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == LAST ? CALC : LOAD;
            end
            CALC: begin
                range_d = max_q - min_q;
                state_d = PROC;
            end
            PROC: begin
                cnt_d   = cnt_q == DEPTH ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == DEPTH ? PRE : PROC;
            end
            PRE: begin
                out_re  = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                out_re  = cnt_q != LAST;
                out_ra  = ADDR_WIDTH'(cnt_q + 1'b1);
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == LAST ? DONE : OUT;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (!en_i_top_contrast && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            min_d   = '1;
            max_d   = '0;
            in_we   = 1'b0;
            out_re  = 1'b0;
        end
    end

    always_ff @(posedge clk_i_top_contrast) begin
        if (rst_i_top_contrast) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            min_q          <= '1;
            max_q          <= '0;
            range_q        <= '0;
            done_process_q <= 1'b0;
            done_o_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            min_q          <= min_d;
            max_q          <= max_d;
            range_q        <= range_d;
            done_process_q <= state_d inside {PRE, OUT, DONE};
            done_o_q       <= state_d == DONE;
        end
    end

    contrast_ram #(.DATA_WIDTH(DATA_WIDTH), .RAM_DEPTH(RAM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_in (
        .clk_i(clk_i_top_contrast),
        .rst_i(rst_i_top_contrast),
        .we_i (in_we),
        .wa_i (cnt_q[ADDR_WIDTH-1:0]),
        .wd_i (data_i_top_contrast),
        .re_i (in_re),
        .ra_i (cnt_q[ADDR_WIDTH-1:0]),
        .rd_o (in_rd)
    );

    contrast_ram #(.DATA_WIDTH(DATA_WIDTH), .RAM_DEPTH(RAM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_out (
        .clk_i(clk_i_top_contrast),
        .rst_i(rst_i_top_contrast),
        .we_i (out_we),
        .wa_i (ADDR_WIDTH'(cnt_q - 1'b1)),
        .wd_i (pix_out),
        .re_i (out_re),
        .ra_i (out_ra),
        .rd_o (data_o_top_contrast)
    );

    assign done_process        = done_process_q;
    assign done_o_top_contrast = done_o_q;
endmodule

// File: tb/tb_top_contrast_stretching.sv
// tb_top_contrast_stretching: table, corner-case and random frame checks against a reference model
module tb_top_contrast_stretching;
    localparam int D = 4;
    typedef logic [7:0] frame_t [D];
    typedef struct {
        string  name;
        frame_t px;
        frame_t ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic done_process, done_o;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    top_contrast_stretching #(.DATA_WIDTH(8), .RAM_DEPTH(D)) dut (
        .clk_i_top_contrast (clk),
        .rst_i_top_contrast (rst),
        .en_i_top_contrast  (en),
        .data_i_top_contrast(din),
        .data_o_top_contrast(dout),
        .done_process       (done_process),
        .done_o_top_contrast(done_o)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input frame_t px, output frame_t ex);
        int mn, mx;
        mn = 255;
        mx = 0;
        foreach (px[i]) begin
            if (int'(px[i]) < mn) mn = int'(px[i]);
            if (int'(px[i]) > mx) mx = int'(px[i]);
        end
        foreach (px[i]) ex[i] = (mx == mn) ? 8'd0 : 8'(((int'(px[i]) - mn) * 255) / (mx - mn));
    endtask

    task automatic load_and_wait(input frame_t px, input string name);
        int n;
        en = 1'b1;
        tick();
        for (int i = 0; i < D; i++) begin
            din = px[i];
            tick();
        end
        din = 8'($urandom);
        n = 0;
        while (!done_process && n < 100) begin
            tick();
            n++;
        end
        check({name, " done_process rise"}, int'(done_process), 1);
        check({name, " done_o low in PRE"}, int'(done_o), 0);
    endtask

    task automatic run_frame(input frame_t px, input frame_t ex, input string name);
        int early;
        load_and_wait(px, name);
        early = 0;
        for (int k = 0; k < D; k++) begin
            tick();
            check($sformatf("%s pixel %0d", name, k), int'(dout), int'(ex[k]));
            if (done_o) early++;
        end
        check({name, " done_o early"}, early, 0);
        tick();
        check({name, " done_o"}, int'(done_o), 1);
        check({name, " hold last"}, int'(dout), int'(ex[D-1]));
        tick();
        check({name, " done_process in DONE"}, int'(done_process), 1);
        en = 1'b0;
        tick();
        check({name, " flags cleared"}, int'(done_process) + int'(done_o), 0);
    endtask

    initial begin
        vec_t tbl [5];
        frame_t px, ex;
        int stuck;
        tbl[0] = '{name: "ramp",   px: '{50, 100, 150, 200}, ex: '{0, 85, 170, 255}};
        tbl[1] = '{name: "flat",   px: '{7, 7, 7, 7},        ex: '{0, 0, 0, 0}};
        tbl[2] = '{name: "full",   px: '{0, 255, 128, 64},   ex: '{0, 255, 128, 64}};
        tbl[3] = '{name: "range30", px: '{10, 20, 30, 40},   ex: '{0, 85, 170, 255}};
        tbl[4] = '{name: "second", px: '{100, 110, 100, 110}, ex: '{0, 255, 0, 255}};

        repeat (3) tick();
        check("reset data_o", int'(dout), 0);
        check("reset done_process", int'(done_process), 0);
        check("reset done_o", int'(done_o), 0);
        rst = 1'b0;
        tick();

        foreach (tbl[t]) run_frame(tbl[t].px, tbl[t].ex, tbl[t].name);

        en = 1'b1;
        tick();
        din = 8'd33;
        tick();
        din = 8'd44;
        tick();
        rst = 1'b1;
        en = 1'b0;
        tick();
        check("midload rst data_o", int'(dout), 0);
        check("midload rst flags", int'(done_process) + int'(done_o), 0);
        rst = 1'b0;
        tick();
        run_frame('{90, 30, 60, 120}, '{170, 0, 85, 255}, "after rst");

        load_and_wait('{5, 15, 25, 35}, "abort");
        tick();
        tick();
        check("abort pre-drop pixel", int'(dout), 85);
        en = 1'b0;
        tick();
        check("abort done_process", int'(done_process), 0);
        check("abort data_o held", int'(dout), 85);
        stuck = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o) stuck++;
            tick();
        end
        check("abort done_o never", stuck, 0);
        run_frame('{200, 100, 0, 50}, '{255, 127, 0, 63}, "after abort");

        for (int r = 0; r < 12; r++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = (r % 4 == 0) ? a : int'($urandom_range(a, 255));
            foreach (px[i]) px[i] = 8'($urandom_range(a, b));
            model(px, ex);
            run_frame(px, ex, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/top_contrast_stretching.md
Name: top_contrast_stretching

Overview:
Frame-based linear contrast stretcher for 8-bit grayscale images of RAM_DEPTH pixels (default 320x240).
- Streams one frame into an internal input RAM while tracking min/max.
- Remaps every pixel to the full 0..255 range into an output RAM.
- Streams the result out one pixel per clock.
- Sits between a pixel source and an image sink or file dump in the image-processing chain.

Parameters:
DATA_WIDTH, 8, pixel width in bits (arithmetic below assumes 8; full-scale value 2^DATA_WIDTH-1).
RAM_DEPTH, 76800, pixels per frame.
ADDR_WIDTH, $clog2(RAM_DEPTH), RAM address/counter width.

Ports:
clk_i_top_contrast  input  1  single clock; all logic on its rising edge.
rst_i_top_contrast  input  1  reset; synchronous, active-high.
en_i_top_contrast  input  1  frame enable; must be held high for the whole frame.
data_i_top_contrast  input  DATA_WIDTH  input pixel stream.
data_o_top_contrast  output  DATA_WIDTH  stretched pixel stream.
done_process  output  1  level: processing finished, output phase active.
done_o_top_contrast  output  1  level: last output pixel delivered.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: state IDLE; all counters 0; min=all-ones, max=0; data_o=0, done_process=0, done_o=0. RAM contents are not cleared.
- IDLE: when en=1, go to LOAD; no pixel is captured in this cycle.
- LOAD:
  - Each cycle, write data_i to RAM_IN[cnt], cnt++.
  - min/max are updated with data_i in the same cycle.
  - After RAM_DEPTH captures (cnt=RAM_DEPTH-1 written), go to CALC.
- CALC (1 cycle): register range = max-min (8 bits), then go to PROC.
- PROC:
  - Read RAM_IN sequentially; 1-cycle read latency.
  - out = ((p-min)*255)/range, 16-bit product, truncating integer division (combinational or pipelined divider allowed).
  - Write out to RAM_OUT at the same index.
  - If range=0 (flat image), out=0 for every pixel.
  - Result can never exceed 255.
  - PROC lasts RAM_DEPTH cycles plus pipeline depth; then go to PRE.
- PRE (1 cycle):
  - Issue RAM_OUT read of address 0.
  - done_process rises here and stays 1 through OUT and DONE.
- OUT:
  - On the k-th cycle in OUT (k=0..RAM_DEPTH-1), data_o=RAM_OUT[k].
  - data_o is registered and held stable for that whole cycle.
  - After k=RAM_DEPTH-1, go to DONE.
- DONE:
  - done_o=1 and data_o holds the last pixel.
  - When en=0, clear done_process/done_o, reset min/max, and go to IDLE.
- en=0 in LOAD/CALC/PROC/PRE/OUT aborts:
  - Go to IDLE; counters reset; min/max reset; flags cleared.
  - data_o holds its last value.
- Reset in any state has priority over en.
- A new frame always restarts min/max; there is no carry-over between frames.
- data_i is ignored outside LOAD.

Decomposition:
- Package contrast_pkg: state enum (IDLE, LOAD, CALC, PROC, PRE, OUT, DONE) and the full-scale constant (2^DATA_WIDTH-1).
- One sub-module, contrast_ram: simple dual-port synchronous RAM (1 write port, 1 registered read port), parameterised by DATA_WIDTH/RAM_DEPTH. It is instantiated twice (RAM_IN, RAM_OUT).

Test Plan:
- RAM_DEPTH=4, input 50,100,150,200 -> done_process rises after load+processing; OUT stream 0,85,170,255; done_o=1 exactly RAM_DEPTH cycles after OUT starts.
- RAM_DEPTH=4, input 7,7,7,7 (range 0) -> output 0,0,0,0; no X, no divide fault.
- RAM_DEPTH=4, input 0,255,128,64 -> output unchanged 0,255,128,64.
- RAM_DEPTH=4, input 10,20,30,40 (range 30) -> output 0,85,170,255; then drop en, send second frame 100,110,100,110 -> 0,255,0,255 (min/max recomputed).
- Assert rst mid-LOAD after 2 pixels -> next cycle all outputs 0, state IDLE; a full subsequent frame processes correctly.
- Drop en during OUT -> done_process=0 next cycle, done_o never asserts, returns to IDLE.
